// File: rtl/mel_frame_scheduler.sv
// Frame scheduler for the mel filterbank: starts passes, captures energies
// into ping-pong banks, streams finished banks out, aborts hung passes.
module mel_frame_scheduler #(
    parameter int NUM_FILTERS    = 40,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_valid_i,
    output logic        frame_ready_o,
    output logic        frame_release_o,
    output logic        mel_start_o,
    input  logic        mel_done_i,
    input  logic        mel_we_i,
    input  logic [5:0]  mel_idx_i,
    input  logic [7:0]  mel_val_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_data_o,
    output logic [5:0]  out_idx_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [15:0] frames_done_o,
    output logic [7:0]  err_count_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0] NF = 7'(NUM_FILTERS);
    localparam logic [5:0] LAST_IDX = 6'(NUM_FILTERS - 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        COMMIT,
        ABORT
    } state_t;

    state_t state, state_nxt;

    logic [7:0]             mem  [2][NUM_FILTERS];
    logic [NUM_FILTERS-1:0] mask [2];
    logic [1:0]             full;
    logic                   fp;
    logic                   dp;
    logic [5:0]             rd_idx;
    logic [CW-1:0]          wd_cnt;
    logic [15:0]            frames_done;
    logic [7:0]             err_count;

    logic accept;
    logic wr_en;
    logic drain_hs;
    logic drain_end;

    // Ready is forced low while reset is held so every output reads 0.
    assign frame_ready_o = rst_n && (state == IDLE) && !full[fp];
    assign accept        = frame_valid_i && frame_ready_o;
    assign wr_en         = (state == RUN) && mel_we_i && ({1'b0, mel_idx_i} < NF);
    assign drain_hs      = out_valid_o && out_ready_i;
    assign drain_end     = drain_hs && (rd_idx == LAST_IDX);

    assign mel_start_o     = (state == START);
    assign frame_release_o = (state == COMMIT) || (state == ABORT);
    assign timeout_o       = (state == ABORT);
    assign busy_o          = (state != IDLE);
    assign frames_done_o   = frames_done;
    assign err_count_o     = err_count;

    assign out_valid_o = full[dp];
    assign out_idx_o   = rd_idx;
    assign out_last_o  = full[dp] && (rd_idx == LAST_IDX);
    assign out_data_o  = (full[dp] && mask[dp][rd_idx]) ? mem[dp][rd_idx] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   state_nxt = RUN;
            RUN: begin
                if (mel_done_i) begin
                    state_nxt = COMMIT;
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt = ABORT;
                end
            end
            COMMIT:  state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Energy storage carries no reset; the written masks gate stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[fp][mel_idx_i] <= mel_val_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask[0]     <= '0;
            mask[1]     <= '0;
            full        <= 2'b00;
            fp          <= 1'b0;
            dp          <= 1'b0;
            rd_idx      <= '0;
            wd_cnt      <= '0;
            frames_done <= '0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                mask[fp] <= '0;
            end
            if (wr_en) begin
                mask[fp][mel_idx_i] <= 1'b1;
            end
            if (state == START) begin
                wd_cnt <= '0;
            end else if (state == RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (drain_hs) begin
                if (drain_end) begin
                    full[dp] <= 1'b0;
                    rd_idx   <= '0;
                    dp       <= ~dp;
                end else begin
                    rd_idx <= rd_idx + 6'd1;
                end
            end
            // A filling bank is never full, so this cannot collide with the drain clear.
            if (state == COMMIT) begin
                full[fp]    <= 1'b1;
                fp          <= ~fp;
                frames_done <= frames_done + 16'd1;
            end
            if ((state == ABORT) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mel_frame_scheduler.sv
// Directed bench for mel_frame_scheduler: single frame, sparse, back-pressure,
// watchdog abort, simultaneous commit/drain and mid-operation reset.
module tb_mel_frame_scheduler;

    localparam int NF = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_valid_i;
    logic        frame_ready_o;
    logic        frame_release_o;
    logic        mel_start_o;
    logic        mel_done_i;
    logic        mel_we_i;
    logic [5:0]  mel_idx_i;
    logic [7:0]  mel_val_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic [5:0]  out_idx_o;
    logic        out_last_o;
    logic        busy_o;
    logic        timeout_o;
    logic [15:0] frames_done_o;
    logic [7:0]  err_count_o;

    int checks = 0;
    int failures = 0;
    int rel_cnt = 0;
    int to_cnt = 0;

    logic [7:0] exp_bank [NF];
    logic [5:0] w_idx [64];
    logic [7:0] w_val [64];

    always #5 clk = ~clk;

    mel_frame_scheduler #(
        .NUM_FILTERS(NF),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_o),
        .frame_release_o(frame_release_o),
        .mel_start_o(mel_start_o),
        .mel_done_i(mel_done_i),
        .mel_we_i(mel_we_i),
        .mel_idx_i(mel_idx_i),
        .mel_val_i(mel_val_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o(out_data_o),
        .out_idx_o(out_idx_o),
        .out_last_o(out_last_o),
        .busy_o(busy_o),
        .timeout_o(timeout_o),
        .frames_done_o(frames_done_o),
        .err_count_o(err_count_o)
    );

    always @(negedge clk) begin
        if (rst_n && frame_release_o) rel_cnt++;
        if (rst_n && timeout_o) to_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag);
        int n;
        n = 0;
        frame_valid_i = 1'b1;
        while (!frame_ready_o && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, frame_ready_o, 1);
        tick();
        frame_valid_i = 1'b0;
        chk({tag, "_start"}, mel_start_o, 1);
        tick();
        chk({tag, "_busy"}, busy_o, 1);
    endtask

    task automatic run_pass(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            mel_we_i   = 1'b1;
            mel_idx_i  = w_idx[i];
            mel_val_i  = w_val[i];
            mel_done_i = (i == n - 1);
            tick();
        end
        if (n == 0) begin
            mel_done_i = 1'b1;
            tick();
        end
        mel_we_i   = 1'b0;
        mel_done_i = 1'b0;
        chk({tag, "_release"}, frame_release_o, 1);
        tick();
    endtask

    task automatic drain(input string tag);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        out_ready_i = 1'b1;
        while (k < NF && cyc < 400) begin
            if (out_valid_o) begin
                chk($sformatf("%s_data%0d", tag, k), out_data_o, exp_bank[k]);
                chk($sformatf("%s_idx%0d", tag, k), out_idx_o, k);
                chk($sformatf("%s_last%0d", tag, k), out_last_o, (k == NF - 1));
                k++;
            end
            tick();
            cyc++;
        end
        out_ready_i = 1'b0;
        chk({tag, "_words"}, k, NF);
    endtask

    task automatic set_full(input int base);
        for (int i = 0; i < NF; i++) begin
            w_idx[i] = 6'(i);
            w_val[i] = 8'(base + i);
            exp_bank[i] = 8'(base + i);
        end
    endtask

    initial begin
        int cyc;
        int vcnt;
        logic [7:0] held;
        rst_n = 1'b0;
        frame_valid_i = 1'b0;
        mel_done_i = 1'b0;
        mel_we_i = 1'b0;
        mel_idx_i = '0;
        mel_val_i = '0;
        out_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_ready", frame_ready_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_frames", frames_done_o, 0);
        chk("rst_err", err_count_o, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", frame_ready_o, 1);

        // Single frame: values idx+1
        set_full(1);
        accept("single");
        run_pass("single", NF);
        chk("single_frames", frames_done_o, 1);
        chk("single_valid", out_valid_o, 1);
        drain("single");
        chk("single_relcnt", rel_cnt, 1);

        // Sparse: idx 5 = 0x7F, idx 50 out of range
        for (int i = 0; i < NF; i++) exp_bank[i] = 8'h00;
        exp_bank[5] = 8'h7F;
        w_idx[0] = 6'd5;
        w_val[0] = 8'h7F;
        w_idx[1] = 6'd50;
        w_val[1] = 8'h33;
        accept("sparse");
        run_pass("sparse", 2);
        drain("sparse");
        chk("sparse_frames", frames_done_o, 2);

        // Back-pressure: two frames fill both banks, third held
        set_full(3);
        accept("bpA");
        run_pass("bpA", NF);
        set_full(60);
        accept("bpB");
        run_pass("bpB", NF);
        chk("bp_ready_low", frame_ready_o, 0);
        frame_valid_i = 1'b1;
        vcnt = 0;
        held = out_data_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frame_ready_o || busy_o) vcnt++;
        end
        chk("bp_held", vcnt, 0);
        chk("bp_stall_data", out_data_o, 3);
        chk("bp_stall_stable", out_data_o, held);
        chk("bp_stall_idx", out_idx_o, 0);
        set_full(3);
        drain("bpA");
        chk("bp_ready_after", frame_ready_o, 1);
        set_full(100);
        accept("bpC");
        run_pass("bpC", NF);
        set_full(60);
        drain("bpB");
        set_full(100);
        drain("bpC");
        chk("bp_frames", frames_done_o, 5);

        // Watchdog abort
        accept("wd");
        cyc = 0;
        while (!timeout_o && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("wd_cycles", cyc, 64);
        chk("wd_release", frame_release_o, 1);
        tick();
        chk("wd_err", err_count_o, 1);
        chk("wd_valid", out_valid_o, 0);
        chk("wd_busy", busy_o, 0);
        chk("wd_frames", frames_done_o, 5);
        chk("wd_tocnt", to_cnt, 1);
        set_full(7);
        accept("post_wd");
        run_pass("post_wd", NF);
        drain("post_wd");
        chk("post_wd_frames", frames_done_o, 6);

        // Commit of bank 1 coincides with last handshake of bank 0
        set_full(8'h50);
        accept("simP");
        run_pass("simP", NF);
        accept("simQ");
        out_ready_i = 1'b1;
        for (int k = 0; k < NF - 1; k++) begin
            chk($sformatf("simP_idx%0d", k), out_idx_o, k);
            chk($sformatf("simP_data%0d", k), out_data_o, 8'h50 + k);
            mel_we_i   = (k < 4);
            mel_idx_i  = 6'(k);
            mel_val_i  = 8'hC0 + 8'(k);
            mel_done_i = (k == NF - 2);
            tick();
        end
        mel_we_i = 1'b0;
        mel_done_i = 1'b0;
        chk("sim_release", frame_release_o, 1);
        chk("sim_last_idx", out_idx_o, NF - 1);
        chk("sim_last", out_last_o, 1);
        tick();
        out_ready_i = 1'b0;
        chk("sim_q_valid", out_valid_o, 1);
        chk("sim_q_idx", out_idx_o, 0);
        chk("sim_q_data", out_data_o, 8'hC0);
        chk("sim_ready", frame_ready_o, 1);
        accept("simR");
        run_pass("simR", 0);
        chk("sim_frames", frames_done_o, 9);
        for (int i = 0; i < NF; i++) exp_bank[i] = (i < 4) ? 8'(8'hC0 + i) : 8'h00;
        drain("simQ");
        for (int i = 0; i < NF; i++) exp_bank[i] = 8'h00;
        drain("simR");
        chk("sim_relcnt", rel_cnt, 10);

        // Reset during a pass with a partly drained bank
        set_full(1);
        accept("rstS");
        run_pass("rstS", NF);
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready_i = 1'b0;
        accept("rstT");
        mel_we_i = 1'b1;
        mel_idx_i = 6'd2;
        mel_val_i = 8'h44;
        tick();
        rst_n = 1'b0;
        mel_we_i = 1'b0;
        #1;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_valid", out_valid_o, 0);
        chk("mrst_data", out_data_o, 0);
        chk("mrst_idx", out_idx_o, 0);
        chk("mrst_ready", frame_ready_o, 0);
        chk("mrst_frames", frames_done_o, 0);
        chk("mrst_err", err_count_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid_o) vcnt++;
        end
        out_ready_i = 1'b0;
        chk("mrst_no_stale", vcnt, 0);
        chk("mrst_ready_after", frame_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mel_frame_scheduler.md
# mel_frame_scheduler

Frame-level controller between the power-spectrum stage, the mel filterbank engine and the downstream log-energy consumer (DCT). It accepts a completed power-spectrum frame, starts one mel filterbank pass, captures the per-filter 8-bit log energies into one of two ping-pong banks, and streams each finished bank out over a valid/ready interface. It also releases the spectrum buffer back to upstream and recovers from a hung mel pass with a watchdog.

## Interface
- NUM_FILTERS, 40, filters per frame (bank depth, max 64)
- TIMEOUT_CYCLES, 16384, max cycles from mel_start_o to mel_done_i before abort
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- frame_valid_i  in  1  upstream has a complete spectrum frame; held until accepted
- frame_ready_o  out  1  scheduler can accept a frame; transfer when both high
- frame_release_o  out  1  one-cycle pulse; spectrum buffer may now be overwritten
- mel_start_o  out  1  one-cycle start pulse to mel engine
- mel_done_i  in  1  mel engine finished pass
- mel_we_i  in  1  energy write strobe
- mel_idx_i  in  6  filter index of write
- mel_val_i  in  8  log energy of write
- out_valid_o  out  1  energy word available
- out_ready_i  in  1  consumer accepts word
- out_data_o  out  8  energy value
- out_idx_o  out  6  filter index, 0..NUM_FILTERS-1
- out_last_o  out  1  high with idx NUM_FILTERS-1
- busy_o  out  1  fill FSM not IDLE
- timeout_o  out  1  one-cycle pulse on watchdog abort
- frames_done_o  out  16  committed frames, wraps at 2^16
- err_count_o  out  8  aborted frames, saturates at 255

## Operation
- Storage: two banks of NUM_FILTERS x 8 bit, each with NUM_FILTERS-bit written mask and full flag; fill pointer fp, drain pointer dp, both start at bank 0.
- Fill FSM: IDLE -> START -> RUN -> COMMIT -> IDLE; ABORT path RUN -> ABORT -> IDLE.
- IDLE: frame_ready_o = !full[fp] (combinational). On frame_valid_i & frame_ready_o: clear mask[fp], go START.
- START: mel_start_o = 1, watchdog counter := 0, go RUN.
- RUN: mel_we_i with mel_idx_i < NUM_FILTERS writes bank[fp][idx] and sets mask bit; idx >= NUM_FILTERS ignored; duplicate idx overwrites. mel_done_i -> COMMIT (write in the same cycle is taken). Counter reaching TIMEOUT_CYCLES-1 without done -> ABORT.
- COMMIT: full[fp] := 1, fp toggles, frame_release_o = 1, frames_done_o += 1.
- ABORT: bank discarded (full stays 0, fp unchanged), frame_release_o = 1, timeout_o = 1, err_count_o += 1 saturating.
- mel_we_i / mel_done_i outside RUN ignored.
- Drain: out_valid_o = full[dp]; word = bank[dp][rd_idx], replaced by 0 if mask bit clear. Handshake advances rd_idx; handshake at NUM_FILTERS-1 clears full[dp], rd_idx := 0, dp toggles.
- Both banks full: frame_ready_o low; upstream holds, nothing dropped.

## Timing
- Reset values: all outputs 0; fp = dp = 0, banks empty, FSM IDLE, counters 0. Reset mid-pass discards all data; mel engine shares rst_n.
- Accept at cycle t -> mel_start_o at t+1 -> RUN from t+2.
- mel_done_i at cycle d -> COMMIT at d+1 (frame_release_o, full set) -> out_valid_o first high at d+2 if that bank is at dp.
- Watchdog: abort if done not seen within TIMEOUT_CYCLES cycles of RUN; ABORT cycle follows.
- Drain throughput one word/cycle with out_ready_i held high; out_data_o/out_idx_o stable while out_valid_o & !out_ready_i.
- COMMIT of one bank and final drain handshake of the other in the same cycle: both take effect; frame_ready_o may assert next cycle.

## Test plan
- Single frame: mel writes idx 0..39 value idx+1, done -> 40 words out 1..40, out_last_o with idx 39, frames_done_o = 1, one frame_release_o.
- Back-pressure: out_ready_i low, three frames offered -> frames 1,2 accepted, frame 3 held (frame_ready_o = 0) until first full drain; then accepted, order preserved.
- Sparse writes: only idx 5 (0x7F) and idx 50 written -> stream all 0 except idx 5 = 0x7F; idx 50 ignored.
- Timeout: TIMEOUT_CYCLES = 64, no mel_done_i -> timeout_o pulse, err_count_o = 1, frame_release_o, no output words, next frame proceeds normally.
- Simultaneous: COMMIT on bank 1 in same cycle as last handshake of bank 0 -> bank 1 streams next cycle, new frame accepted.
- Reset mid-RUN and mid-drain -> all outputs 0 next cycle, no stale words after reset release.
